// File: rtl/fetch_queue.sv
// Purpose    : instruction fetch queue between IFU and decode; circular buffer of {pred_taken, instr, tag}.
// Latency    : 1 cycle minimum push-to-head, with no input-to-output bypass.
// Backpressure: stall_out rises at DEPTH-SKID entries; a word arriving while full with no pop is dropped and sets overflow.
//
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   in_valid/in_instr/in_tag/in_pred_taken   word from IFU
//   flush                       redirect from EXU: empties the queue at the next edge
//   stall_out                   back-pressure to IFU (combinational)
//   out_valid/out_ready/out_*   head entry handshake with decode
//   count                       occupancy, 0..DEPTH
//   overflow                    sticky: a word was dropped (cleared only by rst)
module fetch_queue #(
    parameter int DEPTH     = 4,
    parameter int SKID      = 2,
    parameter int XLEN      = 32,
    parameter int INSTR_LEN = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [INSTR_LEN-1:0]       in_instr,
    input  logic [XLEN-1:0]            in_tag,
    input  logic                       in_pred_taken,
    input  logic                       flush,
    output logic                       stall_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTR_LEN-1:0]       out_instr,
    output logic [XLEN-1:0]            out_tag,
    output logic                       out_pred_taken,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int PW      = $clog2(DEPTH);
    localparam int CW      = $clog2(DEPTH+1);
    localparam int ENTRY_W = 1 + INSTR_LEN + XLEN;

    localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - SKID);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;

    logic full;
    logic pop;
    logic push;
    logic drop;

    assign full = (count == FULL_LVL);
    assign pop  = out_valid & out_ready & ~flush;
    // A full queue still accepts a word when the head leaves in the same cycle.
    assign push = in_valid & ~flush & (~full | pop);
    assign drop = in_valid & ~flush & full & ~pop;

    assign out_valid = (count != '0);
    assign stall_out = (count >= STALL_LVL) & ~flush;

    assign {out_pred_taken, out_instr, out_tag} = mem[rd_ptr];

    // Storage carries no reset; out_valid qualifies every read.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= {in_pred_taken, in_instr, in_tag};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                // Pointers are log2(DEPTH) bits, so they wrap modulo DEPTH on their own.
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
            // Sticky: survives flush on purpose so software can see a lost word.
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int SKID  = 2;
    localparam int XLEN  = 32;
    localparam int ILEN  = 32;
    localparam int CW    = $clog2(DEPTH+1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic [ILEN-1:0] in_instr = '0;
    logic [XLEN-1:0] in_tag = '0;
    logic            in_pred_taken = 1'b0;
    logic            flush = 1'b0;
    logic            stall_out;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [ILEN-1:0] out_instr;
    logic [XLEN-1:0] out_tag;
    logic            out_pred_taken;
    logic [CW-1:0]   count;
    logic            overflow;

    fetch_queue #(.DEPTH(DEPTH), .SKID(SKID), .XLEN(XLEN), .INSTR_LEN(ILEN)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_instr(in_instr), .in_tag(in_tag), .in_pred_taken(in_pred_taken),
        .flush(flush), .stall_out(stall_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_tag(out_tag), .out_pred_taken(out_pred_taken),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] tag;
        logic [ILEN-1:0] instr;
        logic            pred;
    } ent_t;

    ent_t q[$];
    bit   m_ovf = 1'b0;
    bit   chk_en = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs at negedge, compare against the queue model,
    // then apply the queue rules to the model at the rising edge.
    task automatic cycle(input bit v, input logic [XLEN-1:0] tg, input bit rdy, input bit fl, input bit rs);
        ent_t e;
        bit   pop;
        bit   push;
        @(negedge clk);
        e.tag   = tg;
        e.instr = $urandom;
        e.pred  = 1'($urandom_range(0, 1));
        in_valid = v; in_tag = e.tag; in_instr = e.instr; in_pred_taken = e.pred;
        out_ready = rdy; flush = fl; rst = rs;
        #1;
        if (chk_en) begin
            check("out_valid", out_valid, q.size() > 0);
            check("count", count, q.size());
            check("stall_out", stall_out, (q.size() >= DEPTH - SKID) && !fl);
            check("overflow", overflow, m_ovf);
            if (q.size() > 0) begin
                check("out_tag", out_tag, q[0].tag);
                check("out_instr", out_instr, q[0].instr);
                check("out_pred", out_pred_taken, q[0].pred);
            end
        end
        pop  = (q.size() > 0) && rdy && !fl;
        push = v && !fl && ((q.size() < DEPTH) || pop);
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_ovf = 1'b0;
        end else if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
            if (v && !push) m_ovf = 1'b1;
        end
    endtask

    initial begin
        logic [XLEN-1:0] t;
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        chk_en = 1'b1;
        #2;
        check("rst_count", count, 0);
        check("rst_valid", out_valid, 0);
        check("rst_stall", stall_out, 0);
        check("rst_ovf", overflow, 0);

        // Fill to the stall threshold, then to full.
        cycle(1, 32'h100, 0, 0, 0);
        cycle(1, 32'h104, 0, 0, 0);
        #2;
        check("fill_cnt2", count, 2);
        check("fill_stall", stall_out, 1);
        cycle(1, 32'h108, 0, 0, 0);
        cycle(1, 32'h10C, 0, 0, 0);
        #2;
        check("fill_cnt4", count, 4);
        check("fill_ovf", overflow, 0);

        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            #2;
            check("drain_tag", out_tag, 32'h100 + 32'(4*i));
            cycle(0, 0, 1, 0, 0);
        end
        #2;
        check("drain_valid", out_valid, 0);
        check("drain_cnt", count, 0);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 4; i++) cycle(1, 32'h300 + 32'(4*i), 0, 0, 0);
        cycle(1, 32'h310, 1, 0, 0);
        #2;
        check("fullpp_cnt", count, 4);
        check("fullpp_ovf", overflow, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);
        #2;
        check("fullpp_tag", out_tag, 32'h310);

        // Overflow: refill and push into a full queue with no pop.
        for (int i = 0; i < 3; i++) cycle(1, 32'h320 + 32'(4*i), 0, 0, 0);
        cycle(1, 32'h3FF, 0, 0, 0);
        #2;
        check("ovf_cnt", count, 4);
        check("ovf_set", overflow, 1);

        // Flush at count 3 with a push and a ready head pending.
        cycle(0, 0, 1, 0, 0);
        #2;
        check("pre_flush_cnt", count, 3);
        cycle(1, 32'h400, 1, 1, 0);
        #2;
        check("flush_cnt", count, 0);
        check("flush_valid", out_valid, 0);
        check("flush_ovf_sticky", overflow, 1);
        cycle(0, 0, 0, 0, 0);

        // Streaming: each word appears at the head one cycle after its push.
        for (int i = 0; i < 10; i++) begin
            t = 32'h500 + 32'(4*i);
            cycle(1, t, 1, 0, 0);
            #2;
            check("stream_valid", out_valid, 1);
            check("stream_tag", out_tag, t);
        end

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 3) != 0), 32'h1000 + 32'(i), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 31) == 0), ($urandom_range(0, 127) == 0));
        end
        cycle(0, 0, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
